// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field positions, register bank enum
// and the store-form classifier used by the decode stage and its scoreboard.
package decode_pkg;

  localparam int OPC_LO = 26;
  localparam int OPC_W  = 6;
  localparam int RD_LO  = 21;
  localparam int RS_LO  = 16;
  localparam int RT_LO  = 11;
  localparam int OFF_LO = 0;
  localparam int OFF_W  = 16;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FLT = 1'b1
  } bank_e;

  // Store-like forms read cmd[25:21] as their second source and write no register.
  function automatic logic st_form(input logic [31:0] cmd);
    return (cmd[29:26] == 4'd0) | ((cmd[31] ^ cmd[30]) & cmd[29] & cmd[28]);
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy-bit scoreboard: one bit per (bank, register), with an issue set
// port, writeback and flush clear ports, and two source plus one dest lookup.
// Same-cycle writeback forwarding is enabled by defining DECODE_BYPASS_EN.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  bank_e         set_bank,
  input  logic [RW-1:0] set_no,
  input  logic          wb_en,
  input  bank_e         wb_bank,
  input  logic [RW-1:0] wb_no,
  input  logic          kill_en,
  input  bank_e         kill_bank,
  input  logic [RW-1:0] kill_no,
  input  bank_e         src1_bank,
  input  logic [RW-1:0] src1_no,
  input  bank_e         src2_bank,
  input  logic [RW-1:0] src2_no,
  input  bank_e         dst_bank,
  input  logic [RW-1:0] dst_no,
  output logic          src1_busy,
  output logic          src2_busy,
  output logic          dst_busy,
  output logic          src1_byp,
  output logic          src2_byp
);

  logic [2*NREG-1:0] busy;
  logic [2*NREG-1:0] busy_nxt;

  // Clears are applied before the set so an issue in the same cycle wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)   busy_nxt[{wb_bank, wb_no}]     = 1'b0;
    if (kill_en) busy_nxt[{kill_bank, kill_no}] = 1'b0;
    if (set_en)  busy_nxt[{set_bank, set_no}]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

`ifdef DECODE_BYPASS_EN
  function automatic logic wb_hit(input bank_e b, input logic [RW-1:0] n);
    return wb_en && (wb_bank == b) && (wb_no == n) && !((b == BANK_INT) && (n == '0));
  endfunction

  assign src1_byp = wb_hit(src1_bank, src1_no);
  assign src2_byp = wb_hit(src2_bank, src2_no);
`else
  assign src1_byp = 1'b0;
  assign src2_byp = 1'b0;
`endif

  assign src1_busy = busy[{src1_bank, src1_no}] & ~src1_byp;
  assign src2_busy = busy[{src2_bank, src2_no}] & ~src2_byp;
  assign dst_busy  = busy[{dst_bank, dst_no}];

endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage between fetch and execute: field extraction, operand capture,
// RAW/WAW hazard stalls via scoreboard, saturating stall-cycle counter.
// Optional same-cycle writeback bypass: define DECODE_BYPASS_EN.
module decode_stage_sb
  import decode_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int NREG        = 32,
  parameter  int STALL_CNT_W = 16,
  localparam int RW          = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_cmd,
  output logic [RW-1:0]          rf_addr1,
  output logic [RW-1:0]          rf_addr2,
  output logic                   rf_fmode1,
  output logic                   rf_fmode2,
  input  logic [XLEN-1:0]        rf_data1,
  input  logic [XLEN-1:0]        rf_data2,
  input  logic                   wb_valid,
  input  logic                   wb_fmode,
  input  logic [RW-1:0]          wb_no,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_opecode,
  output logic [15:0]            out_offset,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_rs,
  output logic [XLEN-1:0]        out_rt,
  output logic [RW-1:0]          out_rd_no,
  output logic [RW-1:0]          out_rs_no,
  output logic [RW-1:0]          out_rt_no,
  output logic                   out_fmode1,
  output logic                   out_fmode2,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic          st;
  logic          writes_rd;
  logic [RW-1:0] rd_no;
  bank_e         bank1, bank2, dst_bank;
  logic          src1_busy, src2_busy, dst_busy;
  logic          src1_byp, src2_byp;
  logic          hazard, fire, set_en, kill_en;
  logic [XLEN-1:0] op1, op2;

  logic          held_set_p1;
  bank_e         held_bank_p1;

  assign st        = st_form(in_cmd);
  assign writes_rd = ~st;
  assign rd_no     = in_cmd[RD_LO +: RW];
  assign rf_addr1  = in_cmd[RS_LO +: RW];
  assign rf_addr2  = st ? in_cmd[RD_LO +: RW] : in_cmd[RT_LO +: RW];
  assign rf_fmode1 = in_cmd[30] & (in_cmd[29:26] != 4'd0);
  assign rf_fmode2 = in_cmd[30];
  assign bank1     = bank_e'(rf_fmode1);
  assign bank2     = bank_e'(rf_fmode2);
  assign dst_bank  = bank_e'(in_cmd[30]);

  assign hazard   = src1_busy | src2_busy | (writes_rd & dst_busy);
  assign in_ready = ~hazard & ~flush & (~out_valid | out_ready);
  assign fire     = in_valid & in_ready;
  // Integer r0 is hardwired, so writes to it never make it busy.
  assign set_en   = fire & writes_rd & ~((dst_bank == BANK_INT) && (rd_no == '0));
  assign kill_en  = flush & out_valid & held_set_p1;

  decode_scoreboard #(
    .NREG (NREG),
    .RW   (RW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_bank  (dst_bank),
    .set_no    (rd_no),
    .wb_en     (wb_valid),
    .wb_bank   (bank_e'(wb_fmode)),
    .wb_no     (wb_no),
    .kill_en   (kill_en),
    .kill_bank (held_bank_p1),
    .kill_no   (out_rd_no),
    .src1_bank (bank1),
    .src1_no   (rf_addr1),
    .src2_bank (bank2),
    .src2_no   (rf_addr2),
    .dst_bank  (dst_bank),
    .dst_no    (rd_no),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .dst_busy  (dst_busy),
    .src1_byp  (src1_byp),
    .src2_byp  (src2_byp)
  );

`ifdef DECODE_BYPASS_EN
  assign op1 = src1_byp ? wb_data : rf_data1;
  assign op2 = src2_byp ? wb_data : rf_data2;
`else
  assign op1 = rf_data1;
  assign op2 = rf_data2;
  logic unused_bypass;
  assign unused_bypass = ^{wb_data, src1_byp, src2_byp};
`endif

  // Stage p1: held decoded instruction, presented to execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_opecode  <= '0;
      out_offset   <= '0;
      out_pc       <= '0;
      out_rs       <= '0;
      out_rt       <= '0;
      out_rd_no    <= '0;
      out_rs_no    <= '0;
      out_rt_no    <= '0;
      out_fmode1   <= 1'b0;
      out_fmode2   <= 1'b0;
      held_set_p1  <= 1'b0;
      held_bank_p1 <= BANK_INT;
      stall_cycles <= '0;
    end else begin
      if (fire) begin
        out_valid    <= 1'b1;
        out_opecode  <= in_cmd[OPC_LO +: OPC_W];
        out_offset   <= in_cmd[OFF_LO +: OFF_W];
        out_pc       <= in_pc;
        out_rs       <= op1;
        out_rt       <= op2;
        out_rd_no    <= rd_no;
        out_rs_no    <= rf_addr1;
        out_rt_no    <= rf_addr2;
        out_fmode1   <= rf_fmode1;
        out_fmode2   <= rf_fmode2;
        held_set_p1  <= set_en;
        held_bank_p1 <= dst_bank;
      end else if (flush || (out_valid && out_ready)) begin
        out_valid <= 1'b0;
      end
      if (in_valid && hazard && !flush)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_decode_stage_sb.sv
// Directed self-checking bench for decode_stage_sb (STALL_CNT_W=4 so saturation is quick).
module tb_decode_stage_sb;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int SCW  = 4;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_FLT = 6'b010001;
  localparam logic [5:0] OP_ST  = 6'b101100;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0] in_cmd;
  logic [RW-1:0] rf_addr1, rf_addr2;
  logic rf_fmode1, rf_fmode2;
  logic [XLEN-1:0] rf_data1, rf_data2;
  logic wb_valid, wb_fmode;
  logic [RW-1:0] wb_no;
  logic [XLEN-1:0] wb_data;
  logic flush, out_valid, out_ready;
  logic [5:0] out_opecode;
  logic [15:0] out_offset;
  logic [XLEN-1:0] out_pc, out_rs, out_rt;
  logic [RW-1:0] out_rd_no, out_rs_no, out_rt_no;
  logic out_fmode1, out_fmode2;
  logic [SCW-1:0] stall_cycles;

  int errs = 0;
  int checks = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [7:0] tag, input logic fm, input logic [4:0] a);
    return {tag, 7'h0, fm, 11'h0, a};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'h0};
  endfunction

  assign rf_data1 = rf_val(8'hA1, rf_fmode1, rf_addr1);
  assign rf_data2 = rf_val(8'hB2, rf_fmode2, rf_addr2);

  decode_stage_sb #(.XLEN(XLEN), .NREG(32), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_cmd(in_cmd),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_fmode1(rf_fmode1), .rf_fmode2(rf_fmode2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_valid(wb_valid), .wb_fmode(wb_fmode),
    .wb_no(wb_no), .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opecode(out_opecode), .out_offset(out_offset), .out_pc(out_pc), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd_no(out_rd_no), .out_rs_no(out_rs_no), .out_rt_no(out_rt_no),
    .out_fmode1(out_fmode1), .out_fmode2(out_fmode2), .stall_cycles(stall_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_cmd = '0; wb_valid = 1'b0; wb_fmode = 1'b0;
    wb_no = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_vld: got %0b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errs++; $display("FAIL reset_pc: got %0h want 0", out_pc); end
    checks++; if (stall_cycles !== 4'd0) begin errs++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h10 + 32'(4 * i); in_cmd = mk(OP_ADD, 5'(20 + i), 5'd10, 5'd11);
      #1;
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_rdy%0d: got %0b want 1", i, in_ready); end
      checks++; if (rf_addr2 !== 5'd11) begin errs++; $display("FAIL stream_addr2: got %0d want 11", rf_addr2); end
      step();
      checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stream_vld%0d: got %0b want 1", i, out_valid); end
      checks++; if (out_pc !== 32'h10 + 32'(4 * i)) begin errs++; $display("FAIL stream_pc%0d: got %0h want %0h", i, out_pc, 32'h10 + 4 * i); end
      checks++; if (out_rd_no !== 5'(20 + i)) begin errs++; $display("FAIL stream_rd%0d: got %0d want %0d", i, out_rd_no, 20 + i); end
      checks++; if (out_rs !== 32'hA100_000A || out_rt !== 32'hB200_000B) begin errs++; $display("FAIL stream_ops: got %0h/%0h want a100000a/b200000b", out_rs, out_rt); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_drain: got %0b want 0", out_valid); end
    checks++; if (stall_cycles !== 4'd0) begin errs++; $display("FAIL stream_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_raw();
    int fire_c;
    fire_c = BYP ? 3 : 4;
    in_valid = 1'b1; in_pc = 32'h100; in_cmd = mk(OP_ADD, 5'd3, 5'd10, 5'd11);
    step();
    checks++; if (out_pc !== 32'h100) begin errs++; $display("FAIL raw_a_pc: got %0h want 100", out_pc); end
    in_pc = 32'h104; in_cmd = mk(OP_ADD, 5'd4, 5'd3, 5'd12);
    for (int c = 0; c < 5; c++) begin
      wb_valid = (c == 3); wb_fmode = 1'b0; wb_no = 5'd3; wb_data = 32'hDEAD_BEEF;
      in_valid = (c <= fire_c);
      #1;
      if (c <= fire_c) begin
        checks++; if (in_ready !== (c == fire_c)) begin errs++; $display("FAIL raw_rdy_c%0d: got %0b want %0b", c, in_ready, c == fire_c); end
      end
      step();
      if (c == fire_c) begin
        exp_stall = BYP ? 3 : 4;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin errs++; $display("FAIL raw_issue: got vld=%0b pc=%0h want 1/104", out_valid, out_pc); end
        checks++; if (out_rs !== (BYP ? 32'hDEAD_BEEF : 32'hA100_0003)) begin errs++; $display("FAIL raw_rs: got %0h want %0h", out_rs, BYP ? 32'hDEAD_BEEF : 32'hA100_0003); end
        checks++; if (stall_cycles !== 4'(exp_stall)) begin errs++; $display("FAIL raw_stall: got %0d want %0d", stall_cycles, exp_stall); end
      end
    end
    wb_valid = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_cmd = mk(OP_ADD, 5'd5, 5'd10, 5'd11);
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_first_rdy: got %0b want 1", in_ready); end
    step();
    out_ready = 1'b0; in_pc = 32'h204; in_cmd = mk(OP_ADD, 5'd6, 5'd10, 5'd11);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_rdy%0d: got %0b want 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_rd_no !== 5'd5) begin errs++; $display("FAIL bp_hold%0d: got vld=%0b pc=%0h rd=%0d want 1/200/5", k, out_valid, out_pc, out_rd_no); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release: got %0b want 1", in_ready); end
    step();
    checks++; if (out_pc !== 32'h204) begin errs++; $display("FAIL bp_second: got %0h want 204", out_pc); end
    in_pc = 32'h208; in_cmd = mk(OP_ADD, 5'd7, 5'd10, 5'd11);
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208) begin errs++; $display("FAIL bp_third: got vld=%0b pc=%0h want 1/208", out_valid, out_pc); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || stall_cycles !== 4'(exp_stall)) begin errs++; $display("FAIL bp_end: got vld=%0b stall=%0d want 0/%0d", out_valid, stall_cycles, exp_stall); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_cmd = mk(OP_FLT, 5'd5, 5'd1, 5'd2);
    #1;
    checks++; if (rf_fmode1 !== 1'b1 || rf_fmode2 !== 1'b1) begin errs++; $display("FAIL fl_fmode: got %0b%0b want 11", rf_fmode1, rf_fmode2); end
    step();
    in_pc = 32'h304; in_cmd = mk(OP_FLT, 5'd6, 5'd5, 5'd3);
    step();
    exp_stall = exp_stall + 1;
    checks++; if (stall_cycles !== 4'(exp_stall)) begin errs++; $display("FAIL fl_hazard_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fl_rdy_flush: got %0b want 0", in_ready); end
    step();
    flush = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_vld: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fl_f5_free: got %0b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_rs_no !== 5'd5) begin errs++; $display("FAIL fl_issue: got vld=%0b pc=%0h rs=%0d want 1/304/5", out_valid, out_pc, out_rs_no); end
    checks++; if (out_rs !== 32'hA101_0005 || out_fmode1 !== 1'b1) begin errs++; $display("FAIL fl_rs: got %0h fm=%0b want a1010005/1", out_rs, out_fmode1); end
    checks++; if (stall_cycles !== 4'(exp_stall)) begin errs++; $display("FAIL fl_stall: got %0d want %0d", stall_cycles, exp_stall); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_r0();
    logic [31:0] cmds [3];
    cmds[0] = mk(OP_ADD, 5'd0, 5'd10, 5'd11);
    cmds[1] = mk(OP_ADD, 5'd0, 5'd12, 5'd13);
    cmds[2] = mk(OP_ADD, 5'd8, 5'd0, 5'd0);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h400 + 32'(4 * i); in_cmd = cmds[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL r0_rdy%0d: got %0b want 1", i, in_ready); end
      step();
    end
    checks++; if (out_pc !== 32'h408 || out_rs !== 32'hA100_0000) begin errs++; $display("FAIL r0_read: got pc=%0h rs=%0h want 408/a1000000", out_pc, out_rs); end
    in_pc = 32'h40C; in_cmd = mk(OP_ST, 5'd9, 5'd10, 5'd0);
    #1;
    checks++; if (rf_addr2 !== 5'd9 || in_ready !== 1'b1) begin errs++; $display("FAIL st_addr2: got addr=%0d rdy=%0b want 9/1", rf_addr2, in_ready); end
    step();
    checks++; if (out_rt_no !== 5'd9 || out_rt !== 32'hB200_0009 || out_opecode !== OP_ST) begin errs++; $display("FAIL st_out: got rt_no=%0d rt=%0h opc=%0h want 9/b2000009/2c", out_rt_no, out_rt, out_opecode); end
    in_pc = 32'h410; in_cmd = mk(OP_ADD, 5'd14, 5'd9, 5'd9);
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL st_no_busy: got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    step();
    checks++; if (stall_cycles !== 4'(exp_stall)) begin errs++; $display("FAIL r0_stall: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_cmd = mk(OP_ADD, 5'd13, 5'd10, 5'd11);
    step();
    in_pc = 32'h504; in_cmd = mk(OP_ADD, 5'd15, 5'd13, 5'd11);
    for (int k = 0; k < (1 << SCW) + 5; k++) begin
      step();
      if (k == 2) begin
        checks++; if (stall_cycles !== 4'(exp_stall + 3)) begin errs++; $display("FAIL sat_mid: got %0d want %0d", stall_cycles, exp_stall + 3); end
      end
    end
    checks++; if (stall_cycles !== 4'hF) begin errs++; $display("FAIL sat_top: got %0d want 15", stall_cycles); end
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h500) begin errs++; $display("FAIL sat_hold: got rdy=%0b pc=%0h want 0/500", in_ready, out_pc); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (stall_cycles !== 4'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL async_rst_ctl: got stall=%0d vld=%0b want 0/0", stall_cycles, out_valid); end
    checks++; if (out_pc !== 32'h0 || out_rd_no !== 5'd0 || out_rs !== 32'h0 || out_opecode !== 6'd0) begin errs++; $display("FAIL async_rst_data: got pc=%0h rd=%0d rs=%0h opc=%0h want 0", out_pc, out_rd_no, out_rs, out_opecode); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL async_rst_sb: got %0b want 1", in_ready); end
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h504) begin errs++; $display("FAIL post_rst_issue: got vld=%0b pc=%0h want 1/504", out_valid, out_pc); end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_raw();
    test_backpressure();
    test_flush();
    test_r0();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
